// File: rtl/score_counter.sv
// score_counter
//   Game score keeper. Hit and bonus pulses deposit credits into a small
//   pending register, which drains into the score at one point per cycle.
//   The score is kept both in binary and as a cascaded 3-digit BCD counter,
//   so the display stage never needs a divider. The score saturates at 999.
//   A high-score register tracks the best score since reset.
//
// Ports
//   i_Clk      in   sole clock, rising edge
//   i_Rst      in   synchronous active-high reset
//   i_Hit      in   pulse, +1 credit
//   i_Bonus    in   pulse, +P_BONUS credits
//   i_Clear    in   pulse, new game (score and pending to 0, high score kept)
//   i_Pause    in   level, freezes draining of pending credits
//   o_Score    out  [9:0] binary score 0..999
//   o_Score0   out  [3:0] BCD ones
//   o_Score1   out  [3:0] BCD tens
//   o_Score2   out  [3:0] BCD hundreds
//   o_HiScore  out  [9:0] highest score since reset
//   o_Busy     out  pending credits nonzero
//   o_Max      out  score equals 999
//
// Derived state (no state register; decoded from pend_q, score_q, i_Pause)
//   state    | meaning
//   ST_IDLE  | no pending credits
//   ST_COUNT | credits pending, draining one per cycle
//   ST_HOLD  | credits pending, paused; new credits still accumulate
//   ST_FULL  | score is 999; credits discarded until clear/reset
module score_counter #(
  parameter int P_BONUS    = 5,
  parameter int P_PEND_MAX = 15
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Hit,
  input  logic       i_Bonus,
  input  logic       i_Clear,
  input  logic       i_Pause,
  output logic [9:0] o_Score,
  output logic [3:0] o_Score0,
  output logic [3:0] o_Score1,
  output logic [3:0] o_Score2,
  output logic [9:0] o_HiScore,
  output logic       o_Busy,
  output logic       o_Max
);

  localparam logic [9:0] SCORE_MAX = 10'd999;
  localparam logic [4:0] BONUS5    = 5'(P_BONUS);
  localparam logic [4:0] PMAX5     = 5'(P_PEND_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HOLD,
    ST_FULL
  } state_e;

  state_e     state;

  logic [9:0] score_q, score_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] hund_q, hund_d;
  logic [3:0] pend_q, pend_d;
  logic [9:0] hi_q, hi_d;

  logic       dec;
  logic [4:0] add;
  logic [4:0] sum;

  // FULL dominates so a saturated score never drains or accepts credits.
  always_comb begin
    if (score_q == SCORE_MAX)   state = ST_FULL;
    else if (pend_q == 4'd0)    state = ST_IDLE;
    else if (i_Pause)           state = ST_HOLD;
    else                        state = ST_COUNT;
  end

  always_comb begin
    score_d = score_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    dec     = (state == ST_COUNT);
    add     = (i_Hit ? 5'd1 : 5'd0) + (i_Bonus ? BONUS5 : 5'd0);
    // Worst case 15 + 1 + 9 = 25 fits in 5 bits before clamping.
    sum     = {1'b0, pend_q} - {4'd0, dec} + add;

    if (i_Clear) begin
      score_d = 10'd0;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      hund_d  = 4'd0;
      pend_d  = 4'd0;
    end else if (state == ST_FULL) begin
      pend_d = 4'd0;
    end else begin
      pend_d = (sum > PMAX5) ? PMAX5[3:0] : sum[3:0];
      if (dec) begin
        score_d = score_q + 10'd1;
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          if (tens_q == 4'd9) begin
            tens_d = 4'd0;
            hund_d = hund_q + 4'd1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
      // Reaching 999 drops any leftover and same-cycle credits.
      if (score_d == SCORE_MAX) pend_d = 4'd0;
    end

    if (score_d > hi_q) hi_d = score_d;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      score_q <= 10'd0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
      pend_q  <= 4'd0;
      hi_q    <= 10'd0;
    end else begin
      score_q <= score_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
    end
  end

  assign o_Score   = score_q;
  assign o_Score0  = ones_q;
  assign o_Score1  = tens_q;
  assign o_Score2  = hund_q;
  assign o_HiScore = hi_q;
  assign o_Busy    = (pend_q != 4'd0);
  assign o_Max     = (score_q == SCORE_MAX);

endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 Parameter P_BONUS, default 5, credits added per i_Bonus pulse (range 1..9).
REQ-002 Parameter P_PEND_MAX, default 15, pending-credit saturation limit (range 9..15).
REQ-003 i_Clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_Rst  in  1  reset, synchronous, active-high.
REQ-005 i_Hit  in  1  single-cycle pulse: award 1 point.
REQ-006 i_Bonus  in  1  single-cycle pulse: award P_BONUS points.
REQ-007 i_Clear  in  1  single-cycle pulse: start new game (score to zero, high score kept).
REQ-008 i_Pause  in  1  level: freeze score advance while high.
REQ-009 o_Score  out  10  current score, binary, 0..999; feeds the 3-digit FND display stage.
REQ-010 o_Score0 / o_Score1 / o_Score2  out  4 each  BCD ones / tens / hundreds of o_Score.
REQ-011 o_HiScore  out  10  highest score since reset, binary.
REQ-012 o_Busy  out  1  high while pending credits are nonzero.
REQ-013 o_Max  out  1  high while score equals 999.

Function
REQ-014 Internal pending register: 4 bits; each edge it is updated to pend - dec + add, then clamped to P_PEND_MAX.
- add = i_Hit*1 + i_Bonus*P_BONUS.
- i_Hit and i_Bonus in the same cycle: add = 1 + P_BONUS.
REQ-015 dec = 1 when pend > 0 and i_Pause = 0 and score < 999; otherwise dec = 0.
REQ-016 When dec = 1, the score increments by exactly 1 on that edge; the score never advances more than 1 per cycle.
REQ-017 Latency: a pulse sampled at edge k yields pend > 0 after edge k; the first score increment is visible after edge k+1.
- Example: a single i_Bonus (P_BONUS=5) completes after edge k+5.
REQ-018 BCD digits are maintained as a cascaded counter, with no divider.
- Ones digit wraps 9 -> 0 and carries into tens.
- Tens digit wraps 9 -> 0 and carries into hundreds.
- o_Score and the BCD digits always represent the same value in the same cycle.
REQ-019 Saturation: when score reaches 999, o_Max = 1, pend is forced to 0, and further credits are discarded; score holds at 999 until i_Clear or reset.
REQ-020 State is derived from registers, with no separate state register:
- IDLE: pend = 0.
- COUNT: pend > 0 and not paused.
- HOLD: pend > 0 and paused.
- FULL: score = 999.
REQ-021 Transitions:
- IDLE -> COUNT on any credit.
- COUNT -> HOLD on i_Pause = 1.
- HOLD -> COUNT on i_Pause = 0.
- COUNT -> IDLE when pend reaches 0.
- Any state -> FULL when score reaches 999.
- FULL -> IDLE on i_Clear.
REQ-022 While paused, incoming credits still accumulate into pend (clamped per REQ-014).
REQ-023 i_Clear takes priority over all other inputs in the same cycle.
- Score and BCD digits go to 0 and pend goes to 0.
- i_Hit and i_Bonus in that cycle are discarded.
REQ-024 High score: on every edge where the next score > o_HiScore, o_HiScore takes the next score value; it updates in the same edge as the score. i_Clear does not change o_HiScore.
REQ-025 o_Busy = (pend != 0); o_Max = (score == 999); both are registered-state decodes with no input-to-output combinational path.

Reset
REQ-026 On i_Rst = 1 at a rising edge, the following are all set to 0: o_Score, o_Score0..2, o_HiScore, pend, o_Busy, o_Max.
REQ-027 Reset overrides i_Clear, i_Hit, i_Bonus and i_Pause in the same cycle, including mid-count, in HOLD and in FULL.
REQ-028 Credits pending at reset are lost; the first edge after reset deassertion behaves as IDLE.

Verification
REQ-029 Reset, then one i_Hit pulse -> after 2 edges o_Score = 1, digits 0/0/1; o_Busy high for exactly 1 cycle.
REQ-030 Preload score 9, then i_Bonus (P_BONUS=5) -> score steps 10..14 over 5 cycles; carry 9 -> 10 gives digits 0/1/0.
REQ-031 i_Hit and i_Bonus in the same cycle with i_Pause = 1 -> pend = 6 and score frozen; release pause -> score +6 after 6 cycles.
REQ-032 Repeated bonuses while paused exceed 15 credits -> pend clamps at 15; unpause -> score advances exactly 15.
REQ-033 Score 997 plus an i_Bonus -> score 999, o_Max = 1, pend = 0, no wrap; then i_Clear -> score 0, o_HiScore stays 999.
REQ-034 i_Clear and i_Hit in the same cycle while pend = 3 -> score 0, pend 0, o_Busy 0 on the next cycle; i_Rst mid-COUNT -> all outputs 0.
